// File: rtl/uart_cmd_pkg.sv
// Shared constants and state type for the UART servo command parser.
// Frames are 0x55 0xAA ID POS_H POS_L CHK.
package uart_cmd_pkg;

    localparam logic [7:0] HDR0      = 8'h55;
    localparam logic [7:0] HDR1      = 8'hAA;
    localparam int         FRAME_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_ID,
        ST_PH,
        ST_PL,
        ST_CHK
    } state_e;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expired_o combinationally on the terminal cycle, restarting from zero.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // A clear in the terminal cycle suppresses the expiry.
    always_comb begin
        hit   = enable_i && !clear_i && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (clear_i || hit) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = hit;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte servo command frames from the UART byte stream, validates
// header/checksum/range and emits one registered command or error pulse.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_SERVO   = 6,
    parameter int POS_MIN     = 500,
    parameter int POS_MAX     = 2500,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  cmd_id,
    output logic [15:0] cmd_pos,
    output logic        cmd_valid,
    output logic        err_chk,
    output logic        err_range,
    output logic        err_timeout,
    output logic        busy
);

    localparam logic [7:0]  ID_LIMIT = 8'(NUM_SERVO);
    localparam logic [15:0] POS_LO   = 16'(POS_MIN);
    localparam logic [15:0] POS_HI   = 16'(POS_MAX);

    state_e      state_q, state_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  posh_q, posh_d;
    logic [7:0]  posl_q, posl_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  cmd_id_q, cmd_id_d;
    logic [15:0] cmd_pos_q, cmd_pos_d;
    logic        valid_q, valid_d;
    logic        chk_q, chk_d;
    logic        range_q, range_d;
    logic        tmo_q, tmo_d;

    logic        timer_clear;
    logic        timer_en;
    logic        timeout_hit;
    logic [15:0] pos_rx;

    assign timer_clear = (state_q == ST_IDLE) || rx_done;
    assign timer_en    = (state_q != ST_IDLE);
    assign pos_rx      = {posh_q, posl_q};

    byte_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expired_o(timeout_hit)
    );

    // A received byte always takes precedence over an expiring timer.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        posh_d    = posh_q;
        posl_d    = posl_q;
        sum_d     = sum_q;
        cmd_id_d  = cmd_id_q;
        cmd_pos_d = cmd_pos_q;
        valid_d   = 1'b0;
        chk_d     = 1'b0;
        range_d   = 1'b0;
        tmo_d     = 1'b0;

        if (rx_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == HDR0) state_d = ST_HDR1;
                end
                ST_HDR1: begin
                    if (rx_data == HDR1) begin
                        state_d = ST_ID;
                    end else if (rx_data != HDR0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ID: begin
                    id_d    = rx_data;
                    sum_d   = rx_data;
                    state_d = ST_PH;
                end
                ST_PH: begin
                    posh_d  = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = ST_PL;
                end
                ST_PL: begin
                    posl_d  = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data != sum_q) begin
                        chk_d = 1'b1;
                    end else if ((id_q >= ID_LIMIT) || (pos_rx < POS_LO) || (pos_rx > POS_HI)) begin
                        range_d = 1'b1;
                    end else begin
                        cmd_id_d  = id_q;
                        cmd_pos_d = pos_rx;
                        valid_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            posh_q    <= '0;
            posl_q    <= '0;
            sum_q     <= '0;
            cmd_id_q  <= '0;
            cmd_pos_q <= '0;
            valid_q   <= 1'b0;
            chk_q     <= 1'b0;
            range_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            posh_q    <= posh_d;
            posl_q    <= posl_d;
            sum_q     <= sum_d;
            cmd_id_q  <= cmd_id_d;
            cmd_pos_q <= cmd_pos_d;
            valid_q   <= valid_d;
            chk_q     <= chk_d;
            range_q   <= range_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cmd_id      = cmd_id_q;
    assign cmd_pos     = cmd_pos_q;
    assign cmd_valid   = valid_q;
    assign err_chk     = chk_q;
    assign err_range   = range_q;
    assign err_timeout = tmo_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int TMO     = 40;
    localparam int NSERVO  = 6;
    localparam int PMIN    = 500;
    localparam int PMAX    = 2500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  cmd_id;
    logic [15:0] cmd_pos;
    logic        cmd_valid;
    logic        err_chk;
    logic        err_range;
    logic        err_timeout;
    logic        busy;

    int testsRun = 0;
    int failCount = 0;

    // Reference model state: bytes of the frame collected so far.
    int mQ[$];
    int mIdle = 0;
    int expId = 0;
    int expPos = 0;
    bit expValid, expChk, expRange, expTmo;
    int tmoPulses = 0;

    logic [7:0] seq[$];

    uart_cmd_parser #(
        .NUM_SERVO  (NSERVO),
        .POS_MIN    (PMIN),
        .POS_MAX    (PMAX),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .cmd_id     (cmd_id),
        .cmd_pos    (cmd_pos),
        .cmd_valid  (cmd_valid),
        .err_chk    (err_chk),
        .err_range  (err_range),
        .err_timeout(err_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("cmd_valid",   32'(cmd_valid),   32'(expValid));
        checkOutput("err_chk",     32'(err_chk),     32'(expChk));
        checkOutput("err_range",   32'(err_range),   32'(expRange));
        checkOutput("err_timeout", 32'(err_timeout), 32'(expTmo));
        checkOutput("cmd_id",      32'(cmd_id),      32'(expId));
        checkOutput("cmd_pos",     32'(cmd_pos),     32'(expPos));
        checkOutput("busy",        32'(busy),        32'(mQ.size() != 0));
    endtask

    // Frame-level model: judge a whole frame once its last byte arrives.
    task automatic modelStep(input logic done, input logic [7:0] data);
        int s;
        int p;
        expValid = 1'b0;
        expChk   = 1'b0;
        expRange = 1'b0;
        expTmo   = 1'b0;
        if (done) begin
            mIdle = 0;
            if (mQ.size() == 0) begin
                if (data == 8'h55) mQ.push_back(int'(data));
            end else if (mQ.size() == 1) begin
                if (data == 8'hAA) mQ.push_back(int'(data));
                else if (data != 8'h55) mQ.delete();
            end else if (mQ.size() == FRAME_LEN - 1) begin
                s = (mQ[2] + mQ[3] + mQ[4]) % 256;
                p = mQ[3] * 256 + mQ[4];
                if (int'(data) != s) expChk = 1'b1;
                else if (mQ[2] >= NSERVO || p < PMIN || p > PMAX) expRange = 1'b1;
                else begin
                    expValid = 1'b1;
                    expId    = mQ[2];
                    expPos   = p;
                end
                mQ.delete();
            end else begin
                mQ.push_back(int'(data));
            end
        end else if (mQ.size() != 0) begin
            mIdle++;
            if (mIdle == TMO) begin
                expTmo = 1'b1;
                mQ.delete();
                mIdle = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, step the model, check every output.
    task automatic applyStimulus(input logic done, input logic [7:0] data);
        rx_done = done;
        rx_data = data;
        @(posedge clk);
        #1;
        modelStep(done, data);
        rx_done = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
        if (err_timeout) tmoPulses++;
        checkAll();
    endtask

    task automatic sendSeq(input int gapMax);
        foreach (seq[i]) begin
            applyStimulus(1'b1, seq[i]);
            if (i != seq.size() - 1) repeat ($urandom_range(0, gapMax)) applyStimulus(1'b0, 8'h00);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mIdle = 0;
        expId = 0;
        expPos = 0;
        expValid = 1'b0;
        expChk = 1'b0;
        expRange = 1'b0;
        expTmo = 1'b0;
    endtask

    initial begin
        logic [7:0]  rid;
        logic [15:0] rpos;
        logic [7:0]  rchk;
        int kind;
        int nSend;

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        reset_n = 1'b1;

        // Good frame, back-to-back bytes.
        seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'hF4, 8'hF7};
        sendSeq(0);
        checkOutput("good_valid", 32'(cmd_valid), 32'd1);
        checkOutput("good_id", 32'(cmd_id), 32'd2);
        checkOutput("good_pos", 32'(cmd_pos), 32'd500);
        applyStimulus(1'b0, 8'h00);
        checkOutput("good_pulse_width", 32'(cmd_valid), 32'd0);

        // Bad checksum leaves held outputs alone.
        seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'hF4, 8'h00};
        sendSeq(1);
        checkOutput("badchk_err", 32'(err_chk), 32'd1);
        checkOutput("badchk_pos", 32'(cmd_pos), 32'd500);
        applyStimulus(1'b0, 8'h00);

        // Header resync, then range rejection and acceptance.
        seq = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'h64, 8'h65};
        sendSeq(0);
        checkOutput("resync_low_range", 32'(err_range), 32'd1);
        seq = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h03, 8'hE8, 8'hEC};
        sendSeq(2);
        checkOutput("resync_pos", 32'(cmd_pos), 32'd1000);

        // Range boundaries.
        seq = '{8'h55, 8'hAA, 8'h06, 8'h05, 8'hDC, 8'hE7};
        sendSeq(0);
        checkOutput("range_id6", 32'(err_range), 32'd1);
        seq = '{8'h55, 8'hAA, 8'h00, 8'h0A, 8'h00, 8'h0A};
        sendSeq(0);
        checkOutput("range_pos2560", 32'(err_range), 32'd1);
        seq = '{8'h55, 8'hAA, 8'h05, 8'h09, 8'hC4, 8'hD2};
        sendSeq(0);
        checkOutput("edge_pos2500", 32'(cmd_valid), 32'd1);
        seq = '{8'h55, 8'hAA, 8'h05, 8'h09, 8'hC5, 8'hD3};
        sendSeq(0);
        checkOutput("edge_pos2501", 32'(err_range), 32'd1);
        seq = '{8'h55, 8'hAA, 8'h00, 8'h01, 8'hF3, 8'hF4};
        sendSeq(0);
        checkOutput("edge_pos499", 32'(err_range), 32'd1);

        // Timeout fires exactly once, then a good frame.
        seq = '{8'h55, 8'hAA, 8'h03};
        sendSeq(0);
        tmoPulses = 0;
        repeat (TMO + 5) applyStimulus(1'b0, 8'h00);
        checkOutput("timeout_once", 32'(tmoPulses), 32'd1);
        checkOutput("timeout_idle", 32'(busy), 32'd0);
        seq = '{8'h55, 8'hAA, 8'h03, 8'h05, 8'hDC, 8'hE4};
        sendSeq(0);
        checkOutput("post_tmo_id", 32'(cmd_id), 32'd3);
        checkOutput("post_tmo_pos", 32'(cmd_pos), 32'd1500);

        // Byte arriving on the terminal cycle beats the timeout.
        seq = '{8'h55, 8'hAA, 8'h04};
        sendSeq(0);
        tmoPulses = 0;
        repeat (TMO - 1) applyStimulus(1'b0, 8'h00);
        seq = '{8'h05, 8'hDC, 8'hE5};
        sendSeq(0);
        checkOutput("race_no_tmo", 32'(tmoPulses), 32'd0);
        checkOutput("race_id", 32'(cmd_id), 32'd4);

        // Mid-frame reset.
        seq = '{8'h55, 8'hAA, 8'h02};
        sendSeq(0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        modelReset();
        checkAll();
        reset_n = 1'b1;
        seq = '{8'h01, 8'hF4, 8'hF7};
        sendSeq(0);
        checkOutput("tail_ignored", 32'(cmd_valid), 32'd0);
        seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'hF4, 8'hF7};
        sendSeq(0);
        checkOutput("after_reset_valid", 32'(cmd_valid), 32'd1);

        // Random traffic: good, corrupted, out-of-range, junk-prefixed, truncated.
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 4);
            rid  = 8'($urandom_range(0, 7));
            rpos = 16'($urandom_range(300, 2700));
            if (kind == 0) begin
                rid  = 8'($urandom_range(0, NSERVO - 1));
                rpos = 16'($urandom_range(PMIN, PMAX));
            end
            rchk = rid + rpos[15:8] + rpos[7:0];
            if (kind == 1) rchk = rchk ^ 8'($urandom_range(1, 255));
            if (kind == 3) repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
            seq = '{8'h55, 8'hAA, rid, rpos[15:8], rpos[7:0], rchk};
            nSend = (kind == 4) ? $urandom_range(1, 5) : 6;
            while (seq.size() > nSend) void'(seq.pop_back());
            sendSeq(2);
            if (kind == 4) repeat (TMO + 2) applyStimulus(1'b0, 8'h00);
            else repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
